// File: rtl/axi_lite_led_regs.sv
// AXI4-Lite register endpoint: four 32-bit RW registers (PATTERN, HALF_PERIOD,
// CTRL, SCRATCH) driving an LED output with an optional hardware blinker.
module axi_lite_led_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LED_WIDTH          = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]              LED
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wstate_t;

  wstate_t         wstate_q, wstate_d;
  logic            aw_hs, w_hs, ar_hs;
  logic            commit;
  logic [1:0]      commit_idx;
  logic [DW-1:0]   commit_data;
  logic [SW-1:0]   commit_strb;
  logic [1:0]      aw_idx_q;
  logic [DW-1:0]   w_data_q;
  logic [SW-1:0]   w_strb_q;
  logic [DW-1:0]   regs_q [4];
  logic            rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic [31:0]     cnt_q;
  logic            phase_q;
  logic            blink_on;
  logic            timing_commit;
  logic [LED_WIDTH-1:0] led_q;
  logic            unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign S_AXI_BRESP = '0;
  assign S_AXI_RRESP = '0;

  // Write FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wstate_q <= W_IDLE;
    else        wstate_q <= wstate_d;
  end

  // Write FSM next-state: advance on whichever handshakes complete
  always_comb begin
    wstate_d = wstate_q;
    unique case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_d = W_RESP;
        else if (aw_hs)    wstate_d = W_HAVE_ADDR;
        else if (w_hs)     wstate_d = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs)  wstate_d = W_RESP;
      W_HAVE_DATA: if (aw_hs) wstate_d = W_RESP;
      W_RESP:      if (S_AXI_BREADY) wstate_d = W_IDLE;
      default:     wstate_d = W_IDLE;
    endcase
  end

  // Write FSM outputs: READYs and BVALID decoded from state, masked in reset
  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    if (!ARESET) begin
      S_AXI_AWREADY = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_DATA);
      S_AXI_WREADY  = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_ADDR);
      S_AXI_BVALID  = (wstate_q == W_RESP);
    end
  end

  // Commit when the second handshake lands; pick latched or live address/data
  always_comb begin
    commit = 1'b0;
    unique case (wstate_q)
      W_IDLE:      commit = aw_hs && w_hs;
      W_HAVE_ADDR: commit = w_hs;
      W_HAVE_DATA: commit = aw_hs;
      default:     commit = 1'b0;
    endcase
    commit_idx  = (wstate_q == W_HAVE_ADDR) ? aw_idx_q : S_AXI_AWADDR[3:2];
    commit_data = (wstate_q == W_HAVE_DATA) ? w_data_q : S_AXI_WDATA;
    commit_strb = (wstate_q == W_HAVE_DATA) ? w_strb_q : S_AXI_WSTRB;
  end

  // Capture whichever half of a write arrives first
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register file with byte-lane write enables
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (commit) begin
      for (int unsigned b = 0; b < SW; b++) begin
        if (commit_strb[b]) regs_q[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
      end
    end
  end

  assign S_AXI_ARREADY = !rvalid_q && !ARESET;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;

  // Read channel: one-cycle latency, data held until accepted
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs_q[S_AXI_ARADDR[3:2]];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign blink_on      = regs_q[2][0] && (regs_q[1] != '0);
  assign timing_commit = commit && ((commit_idx == 2'd1) || (commit_idx == 2'd2));

  // Blink counter and phase; any timing/control write restarts the on-phase
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (timing_commit || !blink_on) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (cnt_q == regs_q[1] - 32'd1) begin
      cnt_q   <= '0;
      phase_q <= !phase_q;
    end else begin
      cnt_q   <= cnt_q + 32'd1;
    end
  end

  // Registered LED drive
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)        led_q <= '0;
    else if (blink_on) led_q <= phase_q ? regs_q[0][LED_WIDTH-1:0] : '0;
    else               led_q <= regs_q[0][LED_WIDTH-1:0];
  end

  assign LED = led_q;

endmodule

// File: tb/tb_axi_lite_led_regs.sv
// Directed self-checking bench for axi_lite_led_regs.
module tb_axi_lite_led_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [3:0]  LED;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_led_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .LED_WIDTH(4)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .LED(LED)
  );

  // Write transaction; called and returns at a negedge
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_done, w_done, aw_hit, w_hit;
    int n;
    aw_done = 0; w_done = 0; n = 0; resp = 2'b11;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done)) begin
      aw_hit = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hit  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK);
      if (aw_hit) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_hit)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
      n++;
      if (n > 20) begin
        tests++; fails++;
        $display("FAIL write_timeout addr=%h got no handshake, required one within 20 cycles", a);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        return;
      end
    end
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID) begin
      @(negedge ACLK);
      n++;
      if (n > 20) begin
        tests++; fails++;
        $display("FAIL bvalid_timeout addr=%h got BVALID=0, required 1 within 20 cycles", a);
        S_AXI_BREADY = 1'b0;
        return;
      end
    end
    resp = S_AXI_BRESP;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
  endtask

  // Read transaction; called and returns at a negedge
  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit hit;
    int n;
    d = '1; resp = 2'b11; n = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    forever begin
      hit = S_AXI_ARREADY;
      @(negedge ACLK);
      if (hit) begin S_AXI_ARVALID = 1'b0; break; end
      n++;
      if (n > 20) begin
        tests++; fails++;
        $display("FAIL ar_timeout addr=%h got no handshake, required one within 20 cycles", a);
        S_AXI_ARVALID = 1'b0;
        return;
      end
    end
    n = 0;
    while (!S_AXI_RVALID) begin
      @(negedge ACLK);
      n++;
      if (n > 20) begin
        tests++; fails++;
        $display("FAIL rvalid_timeout addr=%h got RVALID=0, required 1 within 20 cycles", a);
        return;
      end
    end
    d = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (S_AXI_AWREADY !== 1'b0) begin fails++; $display("FAIL rst_awready got %b required 0", S_AXI_AWREADY); end
    tests++; if (S_AXI_WREADY !== 1'b0) begin fails++; $display("FAIL rst_wready got %b required 0", S_AXI_WREADY); end
    tests++; if (S_AXI_ARREADY !== 1'b0) begin fails++; $display("FAIL rst_arready got %b required 0", S_AXI_ARREADY); end
    tests++; if (S_AXI_BVALID !== 1'b0) begin fails++; $display("FAIL rst_bvalid got %b required 0", S_AXI_BVALID); end
    tests++; if (S_AXI_RVALID !== 1'b0) begin fails++; $display("FAIL rst_rvalid got %b required 0", S_AXI_RVALID); end
    tests++; if (S_AXI_RDATA !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h required 0", S_AXI_RDATA); end
    tests++; if (LED !== 4'h0) begin fails++; $display("FAIL rst_led got %h required 0", LED); end
    @(negedge ACLK); @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    tests++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      fails++; $display("FAIL idle_readys got %b required 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
  endtask

  task automatic test_basic();
    logic [1:0]  resp;
    logic [31:0] d;
    logic [3:0]  s [8];
    int ones;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, resp);
      tests++; if (resp !== 2'b00) begin fails++; $display("FAIL basic_bresp[%0d] got %b required 00", i, resp); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, resp);
      tests++; if (d !== 32'(i + 1)) begin fails++; $display("FAIL basic_rdata[%0d] got %h required %h", i, d, i + 1); end
      tests++; if (resp !== 2'b00) begin fails++; $display("FAIL basic_rresp[%0d] got %b required 00", i, resp); end
    end
    // HALF_PERIOD=2, BLINK_EN=1: LED alternates 0x1/0x0 every two cycles
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      s[k] = LED;
      if (s[k] === 4'h1) ones++;
      @(negedge ACLK);
    end
    for (int k = 0; k < 6; k++) begin
      tests++; if (s[k+2] !== (s[k] ^ 4'h1)) begin
        fails++; $display("FAIL basic_blink[%0d] got %h required %h", k + 2, s[k+2], s[k] ^ 4'h1);
      end
    end
    tests++; if (ones !== 4) begin fails++; $display("FAIL basic_blink_duty got %0d on-samples required 4", ones); end
  endtask

  task automatic test_strobe();
    logic [1:0]  resp;
    logic [31:0] d;
    axi_write(4'hC, 32'h11223344, 4'hF, resp);
    axi_write(4'hC, 32'hAABBCCDD, 4'b0010, resp);
    axi_read(4'hC, d, resp);
    tests++; if (d !== 32'h1122CC44) begin fails++; $display("FAIL strobe_lane1 got %h required 1122cc44", d); end
    axi_write(4'hC, 32'hFFFFFFFF, 4'b0000, resp);
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL strobe_zero_bresp got %b required 00", resp); end
    axi_read(4'hC, d, resp);
    tests++; if (d !== 32'h1122CC44) begin fails++; $display("FAIL strobe_zero_data got %h required 1122cc44", d); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0]  resp;
    logic [31:0] d;
    S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    tests++; if ({S_AXI_WREADY, S_AXI_AWREADY} !== 2'b01) begin
      fails++; $display("FAIL wfirst_readys got w=%b aw=%b required w=0 aw=1", S_AXI_WREADY, S_AXI_AWREADY);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge ACLK);
      tests++; if ({S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID} !== 3'b010) begin
        fails++; $display("FAIL wfirst_wait[%0d] got w=%b aw=%b b=%b required 0 1 0", k, S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID);
      end
    end
    S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    tests++; if (S_AXI_BVALID !== 1'b1) begin fails++; $display("FAIL wfirst_bvalid got %b required 1", S_AXI_BVALID); end
    // Offer a conflicting write while the response is stalled
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'hDEAD; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      tests++; if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100) begin
        fails++; $display("FAIL bstall[%0d] got b=%b aw=%b w=%b required 1 0 0", k, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
      end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    tests++; if (S_AXI_BVALID !== 1'b0) begin fails++; $display("FAIL bstall_release got %b required 0", S_AXI_BVALID); end
    axi_read(4'hC, d, resp);
    tests++; if (d !== 32'h77) begin fails++; $display("FAIL wfirst_data got %h required 77", d); end
    axi_read(4'h0, d, resp);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL bstall_no_leak got %h required 1", d); end
  endtask

  task automatic test_blink();
    logic [1:0] resp;
    logic [3:0] exp;
    axi_write(4'h0, 32'hF, 4'hF, resp);
    axi_write(4'h4, 32'h4, 4'hF, resp);
    axi_write(4'h8, 32'h1, 4'hF, resp);
    for (int k = 0; k < 16; k++) begin
      exp = (((k / 4) % 2) == 0) ? 4'hF : 4'h0;
      tests++; if (LED !== exp) begin fails++; $display("FAIL blink4[%0d] got %h required %h", k, LED, exp); end
      @(negedge ACLK);
    end
    axi_write(4'h4, 32'h0, 4'hF, resp);
    for (int k = 0; k < 6; k++) begin
      tests++; if (LED !== 4'hF) begin fails++; $display("FAIL blink_off[%0d] got %h required f", k, LED); end
      @(negedge ACLK);
    end
  endtask

  task automatic test_collide();
    logic [1:0]  resp;
    logic [31:0] d;
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tests++; if ({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b111) begin
      fails++; $display("FAIL collide_ready got %b required 111", {S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY});
    end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tests++; if ({S_AXI_RVALID, S_AXI_BVALID} !== 2'b11) begin
      fails++; $display("FAIL collide_valid got r=%b b=%b required 1 1", S_AXI_RVALID, S_AXI_BVALID);
    end
    tests++; if (S_AXI_RDATA !== 32'hF) begin fails++; $display("FAIL collide_old got %h required f", S_AXI_RDATA); end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      tests++; if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b10 || S_AXI_RDATA !== 32'hF) begin
        fails++; $display("FAIL collide_hold[%0d] got rv=%b arr=%b d=%h required 1 0 f", k, S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RDATA);
      end
    end
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    tests++; if (S_AXI_RVALID !== 1'b0) begin fails++; $display("FAIL collide_rdone got %b required 0", S_AXI_RVALID); end
    axi_read(4'h0, d, resp);
    tests++; if (d !== 32'h55) begin fails++; $display("FAIL collide_new got %h required 55", d); end
  endtask

  task automatic test_reset_midflight();
    logic [1:0]  resp;
    logic [31:0] d;
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    tests++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin
      fails++; $display("FAIL pre_rst_valid got b=%b r=%b required 1 1", S_AXI_BVALID, S_AXI_RVALID);
    end
    tests++; if (LED !== 4'h5) begin fails++; $display("FAIL pre_rst_led got %h required 5", LED); end
    #2 ARESET = 1'b1;
    #1;
    tests++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin
      fails++; $display("FAIL async_rst_valid got b=%b r=%b required 0 0", S_AXI_BVALID, S_AXI_RVALID);
    end
    tests++; if (LED !== 4'h0) begin fails++; $display("FAIL async_rst_led got %h required 0", LED); end
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    tests++; if (S_AXI_BVALID !== 1'b0) begin fails++; $display("FAIL post_rst_bvalid got %b required 0", S_AXI_BVALID); end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, resp);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL post_rst_reg[%0d] got %h required 0", i, d); end
    end
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    test_reset();
    test_basic();
    test_strobe();
    test_w_before_aw();
    test_blink();
    test_collide();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded 200000 time units, required completion");
    $fatal(1, "watchdog");
  end

endmodule
